// File: rtl/zapper_shot_sequencer_if.sv
// Pin-side bundle between the zapper I/O, the video timing and the shot sequencer.
// The sequencer takes the slave side; whoever drives frames and pins takes the master side.
interface zapper_shot_sequencer_if;
    logic       frame_start;
    logic       active;
    logic       trigger_raw;
    logic       detect_raw;
    logic       game_active;
    logic       reload;
    logic [1:0] flash_mode;
    logic       shot_fired;
    logic       hit;
    logic       miss;
    logic [2:0] bullets_left;
    logic       out_of_ammo;
    logic       busy;

    modport master (
        output frame_start, active, trigger_raw, detect_raw, game_active, reload,
        input  flash_mode, shot_fired, hit, miss, bullets_left, out_of_ammo, busy
    );

    modport slave (
        input  frame_start, active, trigger_raw, detect_raw, game_active, reload,
        output flash_mode, shot_fired, hit, miss, bullets_left, out_of_ammo, busy
    );
endinterface

// File: rtl/zapper_shot_sequencer.sv
// Light-gun shot sequencer: black frame(s), target flash frame(s), detect integration,
// hit/miss scoring and ammunition tracking, all stepped on frame boundaries.
module zapper_shot_sequencer #(
    parameter int BLACK_FRAMES  = 1,
    parameter int TARGET_FRAMES = 1,
    parameter int DETECT_MIN    = 16,
    parameter int MAX_BULLETS   = 7,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    screen_reset,
    zapper_shot_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLACK  = 2'd1,
        TARGET = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0]       BLACK_LAST  = 4'(BLACK_FRAMES - 1);
    localparam logic [3:0]       TARGET_LAST = 4'(TARGET_FRAMES - 1);
    localparam logic [2:0]       FULL_LOAD   = 3'(MAX_BULLETS);
    localparam logic [CNT_W-1:0] DET_MIN     = CNT_W'(DETECT_MIN);

    state_t           state, state_nx;
    logic             trig_s1, trig_s, det_s1, det_s;
    logic             trig_prev, cheat;
    logic [3:0]       frame_cnt;
    logic [CNT_W-1:0] integ;
    logic [2:0]       bullets;
    logic             shot_q, hit_q, miss_q;
    logic             fire, score_hit, score_miss, reload_ok, trig_edge, frame_last;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_nx   = state;
        fire       = 1'b0;
        score_hit  = 1'b0;
        score_miss = 1'b0;
        trig_edge  = trig_s & ~trig_prev;
        reload_ok  = (state == IDLE) & bus.reload;
        frame_last = (state == BLACK) ? (frame_cnt == BLACK_LAST) : (frame_cnt == TARGET_LAST);
        case (state)
            IDLE: begin
                // A reload on the same frame_start swallows the edge.
                if (bus.frame_start && trig_edge && bus.game_active &&
                    bullets != 3'd0 && !bus.reload) begin
                    fire     = 1'b1;
                    state_nx = BLACK;
                end
            end
            BLACK: begin
                if (bus.frame_start) begin
                    if (!bus.game_active) state_nx = HOLD;
                    else if (frame_last)  state_nx = TARGET;
                end
            end
            TARGET: begin
                if (bus.frame_start) begin
                    if (!bus.game_active) begin
                        state_nx = HOLD;
                    end else if (frame_last) begin
                        state_nx = HOLD;
                        if (integ >= DET_MIN && !cheat) score_hit  = 1'b1;
                        else                            score_miss = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.frame_start && !trig_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: all state updates are non-blocking so each flop sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge screen_reset) begin
        if (screen_reset) begin
            state     <= IDLE;
            trig_s1   <= 1'b0;
            trig_s    <= 1'b0;
            det_s1    <= 1'b0;
            det_s     <= 1'b0;
            trig_prev <= 1'b0;
            cheat     <= 1'b0;
            frame_cnt <= '0;
            integ     <= '0;
            bullets   <= FULL_LOAD;
            shot_q    <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            trig_s1 <= bus.trigger_raw;
            trig_s  <= trig_s1;
            det_s1  <= bus.detect_raw;
            det_s   <= det_s1;
            state   <= state_nx;
            shot_q  <= fire;
            hit_q   <= score_hit;
            miss_q  <= score_miss;

            if (bus.frame_start) trig_prev <= trig_s;

            if (reload_ok)  bullets <= FULL_LOAD;
            else if (fire)  bullets <= bullets - 3'd1;

            if (fire)
                frame_cnt <= '0;
            else if (bus.frame_start && (state == BLACK || state == TARGET))
                frame_cnt <= (state_nx != state) ? 4'd0 : frame_cnt + 4'd1;

            // Light during the black frame means the gun sees a lamp, not the screen.
            if (fire)
                cheat <= 1'b0;
            else if (state == BLACK && bus.active && det_s)
                cheat <= 1'b1;

            if (fire)
                integ <= '0;
            else if (state == TARGET && bus.active && det_s && integ != {CNT_W{1'b1}})
                integ <= integ + 1'b1;
        end
    end

    assign bus.flash_mode   = (state == BLACK)  ? 2'd1 :
                              (state == TARGET) ? 2'd2 : 2'd0;
    assign bus.busy         = (state != IDLE);
    assign bus.shot_fired   = shot_q;
    assign bus.hit          = hit_q;
    assign bus.miss         = miss_q;
    assign bus.bullets_left = bullets;
    assign bus.out_of_ammo  = (bullets == 3'd0);
endmodule

// File: tb/tb_zapper_shot_sequencer.sv
// Bench for zapper_shot_sequencer: a frame-level shot model compared every cycle,
// plus directed shot scenarios with hand-computed pulse counts and ammo values.
module tb_zapper_shot_sequencer;
    localparam int B        = 1;
    localparam int T        = 1;
    localparam int DMIN     = 16;
    localparam int MAXB     = 7;
    localparam int FRAME_LEN = 200;
    localparam int FS_POS   = 4;
    localparam int ACT_LO   = 20;
    localparam int ACT_HI   = 180;
    localparam int MID      = 100;

    logic clk = 1'b0;
    logic screen_reset = 1'b1;

    zapper_shot_sequencer_if bus();

    zapper_shot_sequencer #(
        .BLACK_FRAMES (B),
        .TARGET_FRAMES(T),
        .DETECT_MIN   (DMIN),
        .MAX_BULLETS  (MAXB),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .screen_reset(screen_reset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_shot   = 0;
    int n_hit    = 0;
    int n_miss   = 0;
    logic [1:0] mid_flash;
    logic       mid_busy;
    logic [1:0] f0, f1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a shot is "frames elapsed since the edge frame"; -1 when no shot is in flight.
    int  m_frame, m_bullets, m_cnt;
    bit  m_hold, m_cheat, m_prev, t1, t2, d1, d2;
    bit  e_shot, e_hit, e_miss;

    task automatic model_reset();
        m_frame = -1; m_hold = 0; m_bullets = MAXB; m_cnt = 0; m_cheat = 0;
        m_prev = 0; t1 = 0; t2 = 0; d1 = 0; d2 = 0;
        e_shot = 0; e_hit = 0; e_miss = 0;
    endtask

    task automatic model_step();
        bit idle, in_black, in_target, trig_edge;
        idle      = (m_frame < 0) && !m_hold;
        in_black  = (m_frame >= 0) && (m_frame < B);
        in_target = (m_frame >= B);
        e_shot = 0; e_hit = 0; e_miss = 0;
        if (bus.frame_start) begin
            trig_edge = t2 && !m_prev;
            m_prev    = t2;
            if (idle) begin
                if (!bus.reload && trig_edge && bus.game_active && m_bullets > 0) begin
                    e_shot = 1; m_bullets--; m_frame = 0; m_cheat = 0; m_cnt = 0;
                end
            end else if (m_frame >= 0) begin
                if (!bus.game_active) begin
                    m_frame = -1; m_hold = 1;
                end else begin
                    m_frame++;
                    if (m_frame == B + T) begin
                        if (m_cnt >= DMIN && !m_cheat) e_hit = 1;
                        else                           e_miss = 1;
                        m_frame = -1; m_hold = 1;
                    end
                end
            end else if (!t2) begin
                m_hold = 0;
            end
        end
        if (idle && bus.reload) m_bullets = MAXB;
        if (in_black && bus.active && d2)  m_cheat = 1;
        if (in_target && bus.active && d2) m_cnt++;
        t2 = t1; t1 = bus.trigger_raw;
        d2 = d1; d1 = bus.detect_raw;
    endtask

    initial begin
        logic [9:0] exp_v, act_v;
        logic [1:0] e_flash;
        model_reset();
        forever begin
            @(posedge clk or posedge screen_reset);
            if (screen_reset) model_reset();
            else              model_step();
            #1;
            e_flash = (m_frame < 0) ? 2'd0 : (m_frame < B) ? 2'd1 : 2'd2;
            exp_v = {e_flash, e_shot, e_hit, e_miss, 3'(m_bullets),
                     (m_bullets == 0), ((m_frame >= 0) || m_hold)};
            act_v = {bus.flash_mode, bus.shot_fired, bus.hit, bus.miss, bus.bullets_left,
                     bus.out_of_ammo, bus.busy};
            check("cycle_outputs", 32'(act_v), 32'(exp_v));
            n_shot += int'(bus.shot_fired);
            n_hit  += int'(bus.hit);
            n_miss += int'(bus.miss);
        end
    end

    // One frame: inputs settle at cycle 0, frame_start at FS_POS, detect window in cycles.
    task automatic frame(input bit trig, input bit ga, input int det_lo, input int det_n,
                         input bit rl_fs = 1'b0, input int rst_at = -1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.trigger_raw = trig;
                bus.game_active = ga;
            end
            bus.frame_start = (i == FS_POS);
            bus.reload      = rl_fs && (i == FS_POS);
            bus.active      = (i >= ACT_LO) && (i < ACT_HI);
            bus.detect_raw  = (i >= det_lo) && (i < det_lo + det_n);
            if (i == MID) begin
                mid_flash = bus.flash_mode;
                mid_busy  = bus.busy;
            end
            if (i == rst_at) begin
                screen_reset = 1'b1;
                #1;
                check("reset_mid_flash", 32'(bus.flash_mode), 0);
                check("reset_mid_bullets", 32'(bus.bullets_left), 7);
            end else begin
                screen_reset = 1'b0;
            end
        end
    endtask

    task automatic shot(input int det_target, input int det_black);
        frame(1'b1, 1'b1, 50, det_black);
        f0 = mid_flash;
        frame(1'b1, 1'b1, 50, det_target);
        f1 = mid_flash;
        frame(1'b0, 1'b1, 0, 0);
        frame(1'b0, 1'b1, 0, 0);
    endtask

    initial begin
        int s0, h0, m0;
        bus.frame_start = 0; bus.active = 0; bus.trigger_raw = 0; bus.detect_raw = 0;
        bus.game_active = 1; bus.reload = 0;
        repeat (3) @(negedge clk);
        screen_reset = 1'b0;
        @(negedge clk);
        check("rst_bullets", 32'(bus.bullets_left), 7);
        check("rst_flash", 32'(bus.flash_mode), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ooa", 32'(bus.out_of_ammo), 0);
        frame(1'b0, 1'b1, 0, 0);
        frame(1'b0, 1'b1, 0, 0);

        s0 = n_shot; h0 = n_hit; m0 = n_miss;
        shot(40, 0);
        check("hit_shot_count", 32'(n_shot - s0), 1);
        check("hit_count", 32'(n_hit - h0), 1);
        check("hit_no_miss", 32'(n_miss - m0), 0);
        check("hit_frame0_black", 32'(f0), 1);
        check("hit_frame1_target", 32'(f1), 2);
        check("hit_bullets", 32'(bus.bullets_left), 6);

        h0 = n_hit; m0 = n_miss;
        shot(10, 0);
        check("weak_miss", 32'(n_miss - m0), 1);
        check("weak_no_hit", 32'(n_hit - h0), 0);

        h0 = n_hit; m0 = n_miss;
        shot(100, 5);
        check("cheat_miss", 32'(n_miss - m0), 1);
        check("cheat_no_hit", 32'(n_hit - h0), 0);
        check("cheat_bullets", 32'(bus.bullets_left), 4);

        repeat (4) shot(40, 0);
        check("empty_bullets", 32'(bus.bullets_left), 0);
        check("empty_ooa", 32'(bus.out_of_ammo), 1);
        s0 = n_shot;
        frame(1'b1, 1'b1, 0, 0);
        check("empty_not_busy", 32'(mid_busy), 0);
        frame(1'b0, 1'b1, 0, 0);
        check("empty_no_shot", 32'(n_shot - s0), 0);
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
        repeat (2) @(negedge clk);
        check("reload_bullets", 32'(bus.bullets_left), 7);
        check("reload_ooa", 32'(bus.out_of_ammo), 0);

        s0 = n_shot;
        repeat (5) frame(1'b1, 1'b1, 0, 0);
        check("held_hold_flash", 32'(mid_flash), 0);
        check("held_hold_busy", 32'(mid_busy), 1);
        frame(1'b0, 1'b1, 0, 0);
        check("held_release_idle", 32'(mid_busy), 0);
        check("held_one_shot", 32'(n_shot - s0), 1);

        h0 = n_hit; m0 = n_miss;
        frame(1'b1, 1'b1, 0, 0);
        frame(1'b1, 1'b0, 50, 40);
        check("abort_flash", 32'(mid_flash), 0);
        check("abort_busy", 32'(mid_busy), 1);
        frame(1'b0, 1'b1, 0, 0);
        check("abort_no_hit", 32'(n_hit - h0), 0);
        check("abort_no_miss", 32'(n_miss - m0), 0);
        check("abort_bullets", 32'(bus.bullets_left), 5);

        s0 = n_shot;
        frame(1'b1, 1'b1, 0, 0, 1'b1);
        check("reload_edge_no_shot", 32'(n_shot - s0), 0);
        check("reload_edge_bullets", 32'(bus.bullets_left), 7);
        frame(1'b0, 1'b1, 0, 0);

        h0 = n_hit; m0 = n_miss;
        frame(1'b1, 1'b1, 0, 0);
        frame(1'b1, 1'b1, 50, 40, 1'b0, 120);
        frame(1'b0, 1'b1, 0, 0);
        check("reset_no_hit", 32'(n_hit - h0), 0);
        check("reset_no_miss", 32'(n_miss - m0), 0);
        check("reset_bullets_after", 32'(bus.bullets_left), 7);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
